// File: rtl/flash_player_pkg.sv
// Shared definitions for the flash_player three-voice playback engine.
// Holds voice count, bus widths, host register field codes, ctrl bit
// positions, the per-frame address step and the output saturation helper.
package flash_player_pkg;

    localparam int NVOICE      = 3;
    localparam int ASZ         = 24;
    localparam int DSZ         = 16;
    localparam int ACCW        = 18;
    localparam int FRAME_BYTES = 4;

    // Host register field selected by cfg_sel[1:0]
    typedef enum logic [1:0] {
        FLD_START = 2'd0,
        FLD_END   = 2'd1,
        FLD_CTRL  = 2'd2,
        FLD_RSVD  = 2'd3
    } cfg_field_e;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_LOOP = 1;

    // Clamp a mixed accumulator value into the signed 16-bit output range
    function automatic logic [DSZ-1:0] sat_sample(input logic signed [ACCW-1:0] acc);
        if (acc > 18'sd32767)
            return 16'h7FFF;
        else if (acc < -18'sd32768)
            return 16'h8000;
        else
            return acc[DSZ-1:0];
    endfunction

endpackage

// File: rtl/flash_voice.sv
// One playback voice: start/end/ptr address registers, loop flag and the
// playing flag. Advances ptr by one stereo frame on each completed frame
// and stops or wraps when the end address (or the top of flash) is reached.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   cfg_we       host write strobe already qualified for this voice
//   cfg_field    register field being written
//   cfg_wdata    write data
//   frame_done   second word of this voice's flash cycle arrived
//   ptr          current read address
//   act          voice is playing
module flash_voice
    import flash_player_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           cfg_we,
    input  cfg_field_e     cfg_field,
    input  logic [ASZ-1:0] cfg_wdata,
    input  logic           frame_done,
    output logic [ASZ-1:0] ptr,
    output logic           act
);

    logic [ASZ-1:0] start_addr;
    logic [ASZ-1:0] end_addr;
    logic           loop_en;
    logic [ASZ-1:0] ptr_next;
    logic           ptr_carry;
    logic           ctrl_disable;

    // Carry out of the address step means the next frame would wrap to 0
    assign {ptr_carry, ptr_next} = {1'b0, ptr} + (ASZ+1)'(FRAME_BYTES);

    // A coincident disable write owns ptr/act, so the frame step is skipped
    assign ctrl_disable = cfg_we && (cfg_field == FLD_CTRL) && !cfg_wdata[CTRL_EN];

    always_ff @(posedge clk) begin
        if (reset) begin
            start_addr <= '0;
            end_addr   <= '0;
            ptr        <= '0;
            loop_en    <= 1'b0;
            act        <= 1'b0;
        end else begin
            if (frame_done && act && !ctrl_disable) begin
                if ((ptr >= end_addr) || ptr_carry) begin
                    if (loop_en)
                        ptr <= start_addr;
                    else
                        act <= 1'b0;
                end else begin
                    ptr <= ptr_next;
                end
            end
            // Config writes come last so they win over the frame step
            if (cfg_we) begin
                case (cfg_field)
                    FLD_START: start_addr <= cfg_wdata;
                    FLD_END:   end_addr   <= cfg_wdata;
                    FLD_CTRL: begin
                        loop_en <= cfg_wdata[CTRL_LOOP];
                        if (!cfg_wdata[CTRL_EN]) begin
                            act <= 1'b0;
                        end else if (!act) begin
                            ptr <= start_addr;
                            act <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/flash_player.sv
// Three-voice flash sample player. Supplies the flash read address for the
// current cycle, captures the L/R word pair returned per cycle, mixes the
// active voices into saturated stereo output once per sample period.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   samp_ena            sample-rate enable / frame boundary
//   cyc_num             flash cycle (0-2 voice, 3 idle)
//   addr                flash read address for the current cycle
//   data, data_stb      flash word and its valid strobe
//   cfg_we/sel/wdata    host register write port
//   voice_act           per-voice playing flags
//   out_l, out_r        mixed signed samples, out_stb marks an update
module flash_player
    import flash_player_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              samp_ena,
    input  logic [1:0]        cyc_num,
    output logic [ASZ-1:0]    addr,
    input  logic [DSZ-1:0]    data,
    input  logic              data_stb,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_sel,
    input  logic [ASZ-1:0]    cfg_wdata,
    output logic [NVOICE-1:0] voice_act,
    output logic [DSZ-1:0]    out_l,
    output logic [DSZ-1:0]    out_r,
    output logic              out_stb
);

    logic [ASZ-1:0]         voice_ptr [NVOICE];
    logic [NVOICE-1:0]      voice_frame;
    logic [1:0]             prev_cyc;
    logic                   word_cnt;
    logic                   cyc_done;
    logic [DSZ-1:0]         cap_l;
    logic signed [ACCW-1:0] acc_l;
    logic signed [ACCW-1:0] acc_r;
    logic signed [ACCW-1:0] add_l;
    logic signed [ACCW-1:0] add_r;
    logic                   cyc_chg;
    logic                   eff_cnt;
    logic                   eff_done;
    logic                   frame_done;
    logic                   act_cur;
    logic                   mix_en;

    // Idle cycle 3 parks the address on voice 0
    always_comb begin
        addr    = voice_ptr[0];
        act_cur = voice_act[0];
        case (cyc_num)
            2'd1: begin
                addr    = voice_ptr[1];
                act_cur = voice_act[1];
            end
            2'd2: begin
                addr    = voice_ptr[2];
                act_cur = voice_act[2];
            end
            default: ;
        endcase
    end

    // A strobe arriving on the clock cyc_num changes already belongs to the new cycle
    assign cyc_chg    = (cyc_num != prev_cyc);
    assign eff_cnt    = cyc_chg ? 1'b0 : word_cnt;
    assign eff_done   = cyc_chg ? 1'b0 : cyc_done;
    assign frame_done = data_stb && (cyc_num != 2'd3) && eff_cnt && !eff_done;
    assign mix_en     = frame_done && act_cur;

    assign add_l = {{(ACCW-DSZ){cap_l[DSZ-1]}}, cap_l};
    assign add_r = {{(ACCW-DSZ){data[DSZ-1]}}, data};

    for (genvar v = 0; v < NVOICE; v++) begin : g_voice
        assign voice_frame[v] = frame_done && (cyc_num == 2'(v));

        flash_voice u_voice (
            .clk        (clk),
            .reset      (reset),
            .cfg_we     (cfg_we && (cfg_sel[3:2] == 2'(v))),
            .cfg_field  (cfg_field_e'(cfg_sel[1:0])),
            .cfg_wdata  (cfg_wdata),
            .frame_done (voice_frame[v]),
            .ptr        (voice_ptr[v]),
            .act        (voice_act[v])
        );
    end

    // samp_ena aborts any partial cycle, so the word counter restarts with it
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_cyc <= 2'd0;
            word_cnt <= 1'b0;
            cyc_done <= 1'b0;
            cap_l    <= '0;
        end else begin
            prev_cyc <= cyc_num;
            if (samp_ena) begin
                word_cnt <= 1'b0;
                cyc_done <= 1'b0;
            end else if (data_stb && (cyc_num != 2'd3) && !eff_done) begin
                if (!eff_cnt) begin
                    cap_l    <= data;
                    word_cnt <= 1'b1;
                    cyc_done <= 1'b0;
                end else begin
                    word_cnt <= 1'b0;
                    cyc_done <= 1'b1;
                end
            end else if (cyc_chg) begin
                word_cnt <= 1'b0;
                cyc_done <= 1'b0;
            end
        end
    end

    // A frame completing on the samp_ena clock seeds the freshly cleared accumulators
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_l   <= '0;
            acc_r   <= '0;
            out_l   <= '0;
            out_r   <= '0;
            out_stb <= 1'b0;
        end else begin
            out_stb <= samp_ena;
            if (samp_ena) begin
                out_l <= sat_sample(acc_l);
                out_r <= sat_sample(acc_r);
                acc_l <= mix_en ? add_l : '0;
                acc_r <= mix_en ? add_r : '0;
            end else if (mix_en) begin
                acc_l <= acc_l + add_l;
                acc_r <= acc_r + add_r;
            end
        end
    end

endmodule

// File: tb/tb_flash_player.sv
// Directed self-checking bench for flash_player: one task per scenario,
// a simple flash reader model driving cyc_num/data/data_stb.
module tb_flash_player;

    logic        clk;
    logic        reset;
    logic        samp_ena;
    logic [1:0]  cyc_num;
    logic [23:0] addr;
    logic [15:0] data;
    logic        data_stb;
    logic        cfg_we;
    logic [3:0]  cfg_sel;
    logic [23:0] cfg_wdata;
    logic [2:0]  voice_act;
    logic [15:0] out_l;
    logic [15:0] out_r;
    logic        out_stb;

    int total;
    int bad;

    flash_player dut (
        .clk       (clk),
        .reset     (reset),
        .samp_ena  (samp_ena),
        .cyc_num   (cyc_num),
        .addr      (addr),
        .data      (data),
        .data_stb  (data_stb),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_wdata (cfg_wdata),
        .voice_act (voice_act),
        .out_l     (out_l),
        .out_r     (out_r),
        .out_stb   (out_stb)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        samp_ena  = 1'b0;
        cyc_num   = 2'd3;
        data      = 16'h0000;
        data_stb  = 1'b0;
        cfg_we    = 1'b0;
        cfg_sel   = 4'd0;
        cfg_wdata = 24'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] v, input logic [1:0] f, input logic [23:0] d);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_sel   = {v, f};
        cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic setup_voice(input logic [1:0] v, input logic [23:0] s, input logic [23:0] e,
                               input logic [1:0] ctrl);
        cfg_write(v, 2'd0, s);
        cfg_write(v, 2'd1, e);
        cfg_write(v, 2'd2, {22'd0, ctrl});
    endtask

    // Flash reader model: enter a cycle, report its address, return nstb words
    task automatic do_cycle(input logic [1:0] c, input logic [15:0] l, input logic [15:0] r,
                            input int nstb, output logic [23:0] a);
        @(negedge clk);
        cyc_num = c;
        #1 a = addr;
        for (int i = 0; i < nstb; i++) begin
            @(negedge clk);
            data     = (i == 0) ? l : r;
            data_stb = 1'b1;
            @(negedge clk);
            data_stb = 1'b0;
        end
    endtask

    task automatic pulse_samp();
        @(negedge clk);
        cyc_num  = 2'd3;
        samp_ena = 1'b1;
        @(negedge clk);
        samp_ena = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (voice_act !== 3'b000 || out_l !== 16'h0 || out_r !== 16'h0 || out_stb !== 1'b0 || addr !== 24'h0) begin
            bad++;
            $display("[TB] FAIL reset_state: act=%b l=%h r=%h stb=%b addr=%h need 000/0/0/0/0",
                     voice_act, out_l, out_r, out_stb, addr);
        end
        cfg_write(2'd3, 2'd2, 24'h000001);
        total++;
        if (voice_act !== 3'b000) begin
            bad++;
            $display("[TB] FAIL ignore_voice3: act=%b need 000", voice_act);
        end
        cfg_write(2'd0, 2'd3, 24'h000001);
        total++;
        if (voice_act !== 3'b000) begin
            bad++;
            $display("[TB] FAIL ignore_field3: act=%b need 000", voice_act);
        end
    endtask

    task automatic test_oneshot();
        logic [23:0] a;
        logic [23:0] exp_a [4];
        logic [2:0]  exp_act [4];
        logic [15:0] exp_l [4];
        logic [15:0] exp_r [4];
        exp_a   = '{24'h100, 24'h104, 24'h108, 24'h108};
        exp_act = '{3'b001, 3'b001, 3'b000, 3'b000};
        exp_l   = '{16'h1000, 16'h1000, 16'h1000, 16'h0000};
        exp_r   = '{16'hF000, 16'hF000, 16'hF000, 16'h0000};
        do_reset();
        setup_voice(2'd0, 24'h000100, 24'h000108, 2'b01);
        for (int p = 0; p < 4; p++) begin
            do_cycle(2'd0, 16'h1000, 16'hF000, 2, a);
            total++;
            if (a !== exp_a[p]) begin
                bad++;
                $display("[TB] FAIL oneshot_addr[%0d]: got %h need %h", p, a, exp_a[p]);
            end
            pulse_samp();
            total++;
            if (out_stb !== 1'b1 || out_l !== exp_l[p] || out_r !== exp_r[p]) begin
                bad++;
                $display("[TB] FAIL oneshot_out[%0d]: stb=%b l=%h r=%h need 1 %h %h",
                         p, out_stb, out_l, out_r, exp_l[p], exp_r[p]);
            end
            total++;
            if (voice_act !== exp_act[p]) begin
                bad++;
                $display("[TB] FAIL oneshot_act[%0d]: got %b need %b", p, voice_act, exp_act[p]);
            end
        end
        @(negedge clk);
        total++;
        if (out_stb !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stb_one_cycle: got %b need 0", out_stb);
        end
    endtask

    task automatic test_loop();
        logic [23:0] a;
        logic [23:0] exp_a [5];
        exp_a = '{24'h100, 24'h104, 24'h108, 24'h100, 24'h104};
        do_reset();
        setup_voice(2'd0, 24'h000100, 24'h000108, 2'b11);
        for (int p = 0; p < 5; p++) begin
            do_cycle(2'd0, 16'h1000, 16'hF000, 2, a);
            total++;
            if (a !== exp_a[p]) begin
                bad++;
                $display("[TB] FAIL loop_addr[%0d]: got %h need %h", p, a, exp_a[p]);
            end
            pulse_samp();
            total++;
            if (voice_act !== 3'b001 || out_l !== 16'h1000) begin
                bad++;
                $display("[TB] FAIL loop_act[%0d]: act=%b l=%h need 001 1000", p, voice_act, out_l);
            end
        end
        do_cycle(2'd3, 16'h0, 16'h0, 0, a);
        total++;
        if (a !== 24'h108) begin
            bad++;
            $display("[TB] FAIL idle_addr: got %h need 000108", a);
        end
    endtask

    task automatic test_saturation();
        logic [23:0] a;
        logic [15:0] vl [3][3];
        logic [15:0] vr [3][3];
        logic [15:0] exp_l [3];
        logic [15:0] exp_r [3];
        vl = '{'{16'h7000, 16'h7000, 16'h7000},
               '{16'h9000, 16'h9000, 16'h9000},
               '{16'h7000, 16'h9000, 16'h0001}};
        vr = '{'{16'h0100, 16'h0100, 16'h0100},
               '{16'hFF00, 16'hFF00, 16'hFF00},
               '{16'h8000, 16'h8000, 16'h8000}};
        exp_l = '{16'h7FFF, 16'h8000, 16'h0001};
        exp_r = '{16'h0300, 16'hFD00, 16'h8000};
        do_reset();
        setup_voice(2'd0, 24'h001000, 24'h010000, 2'b01);
        setup_voice(2'd1, 24'h002000, 24'h010000, 2'b01);
        setup_voice(2'd2, 24'h003000, 24'h010000, 2'b01);
        for (int p = 0; p < 3; p++) begin
            for (int v = 0; v < 3; v++) begin
                do_cycle(2'(v), vl[p][v], vr[p][v], 2, a);
                if (p == 1 && v == 2) begin
                    total++;
                    if (a !== 24'h003004) begin
                        bad++;
                        $display("[TB] FAIL sat_addr_v2: got %h need 003004", a);
                    end
                end
            end
            pulse_samp();
            total++;
            if (out_l !== exp_l[p] || out_r !== exp_r[p]) begin
                bad++;
                $display("[TB] FAIL sat_out[%0d]: l=%h r=%h need %h %h", p, out_l, out_r, exp_l[p], exp_r[p]);
            end
        end
    endtask

    task automatic test_abort();
        logic [23:0] a;
        do_reset();
        setup_voice(2'd1, 24'h000200, 24'h000300, 2'b01);
        do_cycle(2'd1, 16'h1234, 16'h5678, 1, a);
        @(negedge clk);
        samp_ena = 1'b1;
        @(negedge clk);
        samp_ena = 1'b0;
        total++;
        if (out_stb !== 1'b1 || out_l !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL abort_out: stb=%b l=%h need 1 0000", out_stb, out_l);
        end
        do_cycle(2'd3, 16'h0, 16'h0, 0, a);
        do_cycle(2'd0, 16'h0, 16'h0, 0, a);
        do_cycle(2'd1, 16'h0010, 16'h0020, 2, a);
        total++;
        if (a !== 24'h000200) begin
            bad++;
            $display("[TB] FAIL abort_ptr: got %h need 000200", a);
        end
        pulse_samp();
        total++;
        if (out_l !== 16'h0010 || out_r !== 16'h0020) begin
            bad++;
            $display("[TB] FAIL abort_mix: l=%h r=%h need 0010 0020", out_l, out_r);
        end
    endtask

    task automatic test_carry();
        logic [23:0] a;
        do_reset();
        setup_voice(2'd2, 24'hFFFFFC, 24'hFFFFFF, 2'b01);
        do_cycle(2'd2, 16'h0ABC, 16'h0DEF, 2, a);
        total++;
        if (a !== 24'hFFFFFC) begin
            bad++;
            $display("[TB] FAIL carry_addr0: got %h need fffffc", a);
        end
        pulse_samp();
        total++;
        if (out_l !== 16'h0ABC || out_r !== 16'h0DEF || voice_act !== 3'b000) begin
            bad++;
            $display("[TB] FAIL carry_stop: l=%h r=%h act=%b need 0abc 0def 000", out_l, out_r, voice_act);
        end
        do_cycle(2'd2, 16'h1111, 16'h2222, 2, a);
        total++;
        if (a !== 24'hFFFFFC) begin
            bad++;
            $display("[TB] FAIL carry_addr1: got %h need fffffc", a);
        end
        pulse_samp();
        total++;
        if (out_l !== 16'h0000 || out_r !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL carry_silent: l=%h r=%h need 0 0", out_l, out_r);
        end
    endtask

    task automatic test_coincident();
        logic [23:0] a;
        do_reset();
        setup_voice(2'd0, 24'h000040, 24'h001000, 2'b01);
        do_cycle(2'd0, 16'h0100, 16'h0000, 1, a);
        @(negedge clk);
        data     = 16'h0200;
        data_stb = 1'b1;
        samp_ena = 1'b1;
        @(negedge clk);
        data_stb = 1'b0;
        samp_ena = 1'b0;
        total++;
        if (out_stb !== 1'b1 || out_l !== 16'h0000 || out_r !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL coinc_first: stb=%b l=%h r=%h need 1 0 0", out_stb, out_l, out_r);
        end
        pulse_samp();
        total++;
        if (out_l !== 16'h0100 || out_r !== 16'h0200) begin
            bad++;
            $display("[TB] FAIL coinc_next: l=%h r=%h need 0100 0200", out_l, out_r);
        end
        do_cycle(2'd0, 16'h0, 16'h0, 0, a);
        total++;
        if (a !== 24'h000044) begin
            bad++;
            $display("[TB] FAIL coinc_ptr: got %h need 000044", a);
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] a;
        do_reset();
        setup_voice(2'd0, 24'h000500, 24'h000600, 2'b01);
        setup_voice(2'd1, 24'h000700, 24'h000800, 2'b01);
        do_cycle(2'd0, 16'h0100, 16'h0200, 2, a);
        do_cycle(2'd1, 16'h0300, 16'h0400, 2, a);
        pulse_samp();
        total++;
        if (out_l !== 16'h0400 || out_r !== 16'h0600) begin
            bad++;
            $display("[TB] FAIL pre_reset_out: l=%h r=%h need 0400 0600", out_l, out_r);
        end
        do_cycle(2'd1, 16'h0777, 16'h0888, 1, a);
        @(negedge clk);
        reset    = 1'b1;
        samp_ena = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        samp_ena = 1'b0;
        total++;
        if (voice_act !== 3'b000 || out_l !== 16'h0 || out_r !== 16'h0 || out_stb !== 1'b0 || addr !== 24'h0) begin
            bad++;
            $display("[TB] FAIL mid_reset: act=%b l=%h r=%h stb=%b addr=%h need 000/0/0/0/0",
                     voice_act, out_l, out_r, out_stb, addr);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_oneshot();
        test_loop();
        test_saturation();
        test_abort();
        test_carry();
        test_coincident();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flash_player.md
Name: flash_player

Overview:
- Three-voice sample playback engine directly downstream of the AT45DB flash SPI reader.
- Supplies the 24-bit read address for each flash cycle and consumes the returned 16-bit words, two per cycle as a stereo L/R pair.
- Mixes the three voices into one saturated stereo sample per sample period.
- The dsPIC host configures voices through a simple register-write port.

Parameters:
- NVOICE, 3, number of voices; one per flash cycle number 0..2 (fixed by flash cycle count).
- ASZ, 24, flash address width.
- DSZ, 16, sample word width.

Ports:
- clk  in  1  24.576MHz system clock
- reset  in  1  synchronous, active-high reset
- samp_ena  in  1  sample-rate enable (1/256); frame boundary
- cyc_num  in  2  current flash cycle from reader (0-2 = voice, 3 = idle)
- addr  out  24  flash read address for the current cycle
- data  in  16  flash read word, valid when data_stb=1
- data_stb  in  1  flash word valid strobe
- cfg_we  in  1  host register write strobe
- cfg_sel  in  4  [3:2] voice 0-2 (3 ignored), [1:0] field: 0 start, 1 end, 2 ctrl, 3 reserved
- cfg_wdata  in  24  write data; ctrl uses bit0 enable, bit1 loop
- voice_act  out  3  per-voice playing flag
- out_l  out  16  mixed left sample, signed
- out_r  out  16  mixed right sample, signed
- out_stb  out  1  one-cycle strobe, out_l/out_r updated

Behaviour:
- Reset:
  - All start/end/ptr = 0, ctrl = 0, voice_act = 0.
  - Accumulators = 0; out_l = out_r = 0; out_stb = 0.
  - Word counter = 0; captured L = 0.
- addr:
  - addr = ptr[cyc_num] for cyc_num 0..2; addr = ptr[0] when cyc_num = 3.
  - Combinational mux of registers only, stable throughout each flash cycle.
- Config writes:
  - Take effect the clock after cfg_we.
  - Writing ctrl with enable=1 while the voice is inactive: ptr <= start, voice_act <= 1.
  - Writing ctrl with enable=0: voice_act <= 0 immediately.
  - start/end writes on an active voice do not move ptr. The new end is used at the next end compare; the new start is used at the next loop.
  - cfg_sel voice 3 or field 3: ignored.
- Word capture:
  - 1-bit word counter, cleared whenever cyc_num changes.
  - First data_stb in a cycle latches L; second supplies R and completes the frame for voice cyc_num.
  - Further strobes in the same cycle are ignored.
  - A cycle aborted by samp_ena or by the write mux has fewer than 2 strobes: the voice contributes nothing and ptr holds.
- Frame completion, on the second strobe, voice v active:
  - acc_l += sext(L), acc_r += sext(R); 18-bit signed accumulators.
  - If ptr >= end, or ptr+4 carries out of 24 bits:
    - loop=1: ptr <= start.
    - loop=0: voice_act[v] <= 0, ptr holds.
  - Otherwise ptr <= ptr+4.
  - If voice v is inactive, there is no accumulation and no ptr change.
- Output on samp_ena:
  - out_l/out_r <= acc saturated to [-32768, 32767].
  - out_stb = 1 on the following clock.
  - Accumulators clear.
- Simultaneous events:
  - samp_ena coincident with a completing second strobe: the frame's samples load into the cleared accumulators, so they count toward the next output.
  - A config write coincident with frame completion on the same voice: the write wins for voice_act and ptr.

Decomposition:
- Shared package: field codes (FLD_START/END/CTRL), ctrl bit indices, FRAME_BYTES = 4, NVOICE.
- Sub-module flash_voice: per-voice start/end/ptr/ctrl registers, activation, end/loop/advance logic; instantiated NVOICE times.
- Mux, word capture, mixer and saturation live in flash_player.

Test Plan:
- Voice 0 start=0x000100, end=0x000108, loop=0, enabled; flash model returns L=0x1000, R=0xF000 -> addr for cyc 0 steps 0x100, 0x104, 0x108. voice_act[0] clears after the third frame. Three out_stb with out_l=0x1000, out_r=0xF000, then 0.
- Same setup with loop=1 -> addr sequence 0x100, 0x104, 0x108, 0x100, ...; voice_act stays 1.
- All three voices active, each returning L=0x7000 -> out_l saturates to 0x7FFF. With L=0x9000 on all voices -> out_l=0x8000.
- Cycle 1 aborted after one strobe by early samp_ena -> voice 1 ptr unchanged, and its L is not mixed into the next output.
- Voice 2 start=0xFFFFFC, end=0xFFFFFF, loop=0 -> one frame plays, then voice_act[2]=0 from carry-out; addr never reads 0x000000.
- Reset asserted mid-cycle with voices active -> next clock: voice_act=0, out_l=out_r=0, out_stb=0, addr=0.
